// File: rtl/if_prefetch_unit_if.sv
// Instruction-memory read bus: fetch unit (master) to a synchronous
// instruction memory (slave) with one cycle of read latency.
interface if_prefetch_unit_if #(
  parameter int LEN    = 32,
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] o_imem_addr;
  logic              o_imem_en;
  logic [LEN-1:0]    i_imem_data;

  modport master (output o_imem_addr, output o_imem_en, input  i_imem_data);
  modport slave  (input  o_imem_addr, input  o_imem_en, output i_imem_data);
endinterface

// File: rtl/if_prefetch_unit.sv
// MIPS instruction-fetch stage with a decoupled prefetch FIFO feeding IF/ID.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_prefetch_unit #(
  parameter int             LEN       = 32,
  parameter int             ADDR_W    = 11,
  parameter int             QDEPTH    = 4,
  parameter int             PC_STEP   = 1,
  parameter int             RESET_PC  = 0,
  parameter logic [LEN-1:0] HALT_WORD = LEN'(32'hFFFF_FFFF)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_stall,
  input  logic               i_jump,
  input  logic [LEN-1:0]     i_jump_addr,
  input  logic               i_branch,
  input  logic [LEN-1:0]     i_branch_addr,
  if_prefetch_unit_if.master imem,
  output logic [LEN-1:0]     o_instr,
  output logic [LEN-1:0]     o_pc_next,
  output logic               o_valid,
  output logic               o_halted,
  output logic [31:0]        o_fetch_cnt,
  output logic [31:0]        o_bubble_cnt
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [LEN-1:0] instr;
    logic [LEN-1:0] pc_next;
  } entry_t;

  typedef enum logic {S_RUN, S_HALTED} state_e;

  state_e           r_state;
  logic [LEN-1:0]   r_pc;
  logic [LEN-1:0]   r_ret_pc;
  logic             r_inflight;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  entry_t           r_fifo [QDEPTH];
  entry_t           r_ifid;
  logic             r_valid;
  logic             r_halted;

  logic             w_redirect;
  logic [LEN-1:0]   w_target;
  logic             w_ret_halt;
  logic             w_fifo_empty;
  logic             w_pop_fifo;
  logic             w_bypass;
  logic             w_pop;
  logic             w_push;
  logic [CNT_W:0]   w_occ;
  logic             w_issue;
  entry_t           w_ret_entry;
  entry_t           w_load_entry;
  logic             w_load_valid;

  assign w_redirect   = i_jump | i_branch;
  assign w_target     = i_jump ? i_jump_addr : i_branch_addr;
  assign w_ret_entry  = '{instr: imem.i_imem_data, pc_next: r_ret_pc};
  assign w_ret_halt   = r_inflight && (imem.i_imem_data == HALT_WORD);
  assign w_fifo_empty = (r_count == '0);

  // An empty FIFO lets the returning word go straight into IF/ID, which gives
  // the two-cycle request-to-decode latency.
  assign w_pop_fifo = !i_stall && !w_fifo_empty;
  assign w_bypass   = !i_stall && w_fifo_empty && r_inflight;
  assign w_pop      = w_pop_fifo | w_bypass;
  assign w_push     = r_inflight && !w_bypass && !w_redirect;

  // Credit counts the word still in flight so the FIFO can never overflow.
  assign w_occ   = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight} - {{CNT_W{1'b0}}, w_pop};
  assign w_issue = (r_state == S_RUN) && !w_redirect && !w_ret_halt &&
                   (w_occ < (CNT_W+1)'(QDEPTH));

  assign imem.o_imem_en   = w_issue;
  assign imem.o_imem_addr = r_pc[ADDR_W-1:0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_load_entry = '0;
    w_load_valid = 1'b0;
    if (w_pop_fifo) begin
      w_load_entry = r_fifo[r_rd_ptr];
      w_load_valid = 1'b1;
    end else if (w_bypass) begin
      w_load_entry = w_ret_entry;
      w_load_valid = 1'b1;
    end
  end

  // NOTE: FIFO storage carries no reset; r_count alone decides which slots are live.
  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_ret_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= S_RUN;
      r_pc       <= LEN'(RESET_PC);
      r_ret_pc   <= '0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ifid     <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else if (w_redirect) begin
      // Flush wins over stall: queue, in-flight word and IF/ID are all dropped.
      r_state    <= S_RUN;
      r_pc       <= w_target;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ifid     <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc     <= r_pc + LEN'(PC_STEP);
        r_ret_pc <= r_pc + LEN'(PC_STEP);
      end
      if (w_ret_halt) r_state <= S_HALTED;

      if (w_push)     r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_fifo) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop_fifo})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase

      if (!i_stall) begin
        r_ifid  <= w_load_entry;
        r_valid <= w_load_valid;
        if (w_load_valid && (w_load_entry.instr == HALT_WORD)) r_halted <= 1'b1;
      end
    end
  end

  assign o_instr   = r_ifid.instr;
  assign o_pc_next = r_ifid.pc_next;
  assign o_valid   = r_valid;
  assign o_halted  = r_halted;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;
  logic        w_bubble_load;

  // A flush loads a bubble too; a stall hold does not.
  assign w_bubble_load = w_redirect || (!i_stall && !w_load_valid);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_issue)       r_fetch_cnt  <= r_fetch_cnt + 32'd1;
      if (w_bubble_load) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt  = r_fetch_cnt;
  assign o_bubble_cnt = r_bubble_cnt;
`else
  assign o_fetch_cnt  = '0;
  assign o_bubble_cnt = '0;
`endif

endmodule
